// File: rtl/usb_status_uart_tx.sv
// Fetches one character per frame over the inc/dout/dout_v handshake and sends it as 8N1 serial.
// Outputs are registered; inc is held until dout_v arrives, and the next fetch waits for IDLE.
module usb_status_uart_tx #(
  parameter int CLKS_PER_BIT = 417,
  parameter int FETCH_CYCLES = 3,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CLKS     = 0
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       enable,
  output logic       inc,
  input  logic [7:0] dout,
  input  logic       dout_v,
  output logic       uart_tx,
  output logic       busy,
  output logic       sent
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65536) begin : g_bad_cpb
    $error("usb_status_uart_tx: CLKS_PER_BIT out of range");
  end
  if (FETCH_CYCLES < 3 || FETCH_CYCLES > 65536) begin : g_bad_fetch
    $error("usb_status_uart_tx: FETCH_CYCLES out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("usb_status_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (GAP_CLKS < 0 || GAP_CLKS > 65536) begin : g_bad_gap
    $error("usb_status_uart_tx: GAP_CLKS out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_START, S_DATA, S_STOP, S_GAP
  } state_t;

  localparam logic [15:0] CPB_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] FETCH_LAST = 16'(FETCH_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CLKS - 1);
  localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);

  state_t      r_state, w_state_n;
  logic [15:0] r_clk_cnt, w_clk_n;
  logic [2:0]  r_bit_cnt, w_bit_n;
  logic [7:0]  r_shreg, w_shreg_n;
  logic        r_inc, w_inc_n;
  logic        r_tx, w_tx_n;
  logic        r_busy, w_busy_n;
  logic        r_sent, w_sent_n;

  always_comb begin
    w_state_n = r_state;
    w_clk_n   = r_clk_cnt;
    w_bit_n   = r_bit_cnt;
    w_shreg_n = r_shreg;
    w_inc_n   = r_inc;
    w_tx_n    = r_tx;
    unique case (r_state)
      S_IDLE: begin
        w_inc_n = 1'b0;
        w_tx_n  = 1'b1;
        if (enable) begin
          w_state_n = S_REQ;
          w_inc_n   = 1'b1;
          w_clk_n   = '0;
        end
      end
      S_REQ: begin
        // Counter parks on the last fetch cycle until the annunciator qualifies dout.
        if (r_clk_cnt == FETCH_LAST) begin
          if (dout_v) begin
            w_shreg_n = dout;
            w_inc_n   = 1'b0;
            w_tx_n    = 1'b0;
            w_clk_n   = '0;
            w_state_n = S_START;
          end
        end else begin
          w_clk_n = r_clk_cnt + 16'd1;
        end
      end
      S_START: begin
        if (r_clk_cnt == CPB_LAST) begin
          w_clk_n   = '0;
          w_bit_n   = '0;
          w_tx_n    = r_shreg[0];
          w_state_n = S_DATA;
        end else begin
          w_clk_n = r_clk_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == CPB_LAST) begin
          w_clk_n = '0;
          if (r_bit_cnt == 3'd7) begin
            w_bit_n   = '0;
            w_tx_n    = 1'b1;
            w_state_n = S_STOP;
          end else begin
            w_bit_n   = r_bit_cnt + 3'd1;
            w_shreg_n = {1'b0, r_shreg[7:1]};
            w_tx_n    = r_shreg[1];
          end
        end else begin
          w_clk_n = r_clk_cnt + 16'd1;
        end
      end
      S_STOP: begin
        w_tx_n = 1'b1;
        if (r_clk_cnt == CPB_LAST) begin
          w_clk_n = '0;
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_n   = '0;
            w_state_n = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
          end else begin
            w_bit_n = r_bit_cnt + 3'd1;
          end
        end else begin
          w_clk_n = r_clk_cnt + 16'd1;
        end
      end
      S_GAP: begin
        w_tx_n = 1'b1;
        if (r_clk_cnt == GAP_LAST) begin
          w_clk_n   = '0;
          w_state_n = S_IDLE;
        end else begin
          w_clk_n = r_clk_cnt + 16'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_inc_n   = 1'b0;
        w_tx_n    = 1'b1;
        w_clk_n   = '0;
        w_bit_n   = '0;
      end
    endcase
    // Flags are derived from the next state so they line up with the registered line.
    w_busy_n = (w_state_n != S_IDLE);
    w_sent_n = (w_state_n == S_STOP) && (w_clk_n == CPB_LAST) && (w_bit_n == STOP_LAST);
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_inc     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_sent    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_clk_cnt <= w_clk_n;
      r_bit_cnt <= w_bit_n;
      r_shreg   <= w_shreg_n;
      r_inc     <= w_inc_n;
      r_tx      <= w_tx_n;
      r_busy    <= w_busy_n;
      r_sent    <= w_sent_n;
    end
  end

  assign inc     = r_inc;
  assign uart_tx = r_tx;
  assign busy    = r_busy;
  assign sent    = r_sent;

endmodule
